// File: rtl/moduloaddsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : moduloaddsub_serial
// Purpose  : Limb-serial modular adder/subtractor. Computes
//            (a_in + b_in) mod MODULUS or (a_in - b_in) mod MODULUS,
//            LIMB_BITS bits per cycle, least significant limb first.
//            A raw chain (T) and a corrected chain (U) run side by side;
//            the final carries pick which one is the reduced result.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            in_valid/in_ready      - operand handshake (a_in, b_in, op_sub)
//            op_sub                 - 0 = add, 1 = subtract
//            a_in, b_in             - operands, expected < MODULUS
//            out_valid/out_ready    - result handshake
//            value_out              - reduced result, held after transfer
// Revision : 1.0 - initial release
// ============================================================================
module moduloaddsub_serial #(
  parameter int                 MOD_LEN   = 1024,
  parameter logic [MOD_LEN-1:0] MODULUS   = '0,
  parameter int                 LIMB_BITS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op_sub,
  input  logic [MOD_LEN-1:0] a_in,
  input  logic [MOD_LEN-1:0] b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MOD_LEN-1:0] value_out
);

  localparam int NUM_LIMBS = MOD_LEN / LIMB_BITS;
  localparam int K_W       = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  localparam logic [K_W-1:0] c_last_limb = K_W'(NUM_LIMBS - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [K_W-1:0]     r_k;
  logic [MOD_LEN-1:0] r_a;
  logic [MOD_LEN-1:0] r_b;
  logic [MOD_LEN-1:0] r_m;
  logic               r_sub;
  logic               r_ct;
  logic               r_cu;
  logic [MOD_LEN-1:0] r_t;
  logic [MOD_LEN-1:0] r_u;
  logic [MOD_LEN-1:0] r_value;

  logic [LIMB_BITS-1:0] w_a_limb;
  logic [LIMB_BITS-1:0] w_b_limb;
  logic [LIMB_BITS-1:0] w_m_limb;
  logic [LIMB_BITS:0]   w_t_sum;
  logic [LIMB_BITS:0]   w_u_sum;
  logic [MOD_LEN-1:0]   w_t_next;
  logic [MOD_LEN-1:0]   w_u_next;
  logic                 w_use_u;
  logic [MOD_LEN-1:0]   w_sel;

  // Subtract inverts B on chain T (carry-in 1 gives a - b).
  // Add inverts M on chain U (carry-in 1 gives T - M); subtract adds M plainly.
  assign w_a_limb = r_a[LIMB_BITS-1:0];
  assign w_b_limb = r_b[LIMB_BITS-1:0] ^ {LIMB_BITS{r_sub}};
  assign w_m_limb = r_m[LIMB_BITS-1:0] ^ {LIMB_BITS{~r_sub}};

  assign w_t_sum = {1'b0, w_a_limb} + {1'b0, w_b_limb}
                 + {{LIMB_BITS{1'b0}}, r_ct};

  // Chain U is fed from the T limb so every adder stays LIMB_BITS+1 wide;
  // in add mode this equals a_k + b_k + ~M_k with the T carry tracked apart.
  assign w_u_sum = {1'b0, w_t_sum[LIMB_BITS-1:0]} + {1'b0, w_m_limb}
                 + {{LIMB_BITS{1'b0}}, r_cu};

  // New limb enters at the top; after NUM_LIMBS shifts limb 0 sits at the bottom.
  assign w_t_next = (r_t >> LIMB_BITS)
                  | (MOD_LEN'(w_t_sum[LIMB_BITS-1:0]) << (MOD_LEN - LIMB_BITS));
  assign w_u_next = (r_u >> LIMB_BITS)
                  | (MOD_LEN'(w_u_sum[LIMB_BITS-1:0]) << (MOD_LEN - LIMB_BITS));

  // Sign decisions from the final carries:
  //   sub: T = a-b is non-negative exactly when the T carry-out is 1.
  //   add: T - M is non-negative when a+b overflowed MOD_LEN bits or the
  //        low MOD_LEN bits alone were >= M (U carry-out).
  assign w_use_u = r_sub ? ~w_t_sum[LIMB_BITS]
                         : (w_t_sum[LIMB_BITS] | w_u_sum[LIMB_BITS]);
  assign w_sel   = w_use_u ? w_u_next : w_t_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_k     <= '0;
      r_ct    <= 1'b0;
      r_cu    <= 1'b0;
      r_value <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_m     <= MODULUS;
            r_sub   <= op_sub;
            r_ct    <= op_sub;
            r_cu    <= ~op_sub;
            r_k     <= '0;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          r_a  <= r_a >> LIMB_BITS;
          r_b  <= r_b >> LIMB_BITS;
          r_m  <= r_m >> LIMB_BITS;
          r_ct <= w_t_sum[LIMB_BITS];
          r_cu <= w_u_sum[LIMB_BITS];
          r_t  <= w_t_next;
          r_u  <= w_u_next;
          if (r_k == c_last_limb) begin
            r_value <= w_sel;
            r_k     <= '0;
            r_state <= c_st_done;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign in_ready  = (r_state == c_st_idle);
  assign out_valid = (r_state == c_st_done);
  assign value_out = r_value;

endmodule
`default_nettype wire

// File: tb/tb_moduloaddsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_moduloaddsub_serial
// Purpose  : Self-checking bench for moduloaddsub_serial with MOD_LEN=16,
//            LIMB_BITS=4, MODULUS=0xFFF1. Inputs change and outputs are
//            sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moduloaddsub_serial;

  localparam int          MOD_LEN   = 16;
  localparam int          LIMB_BITS = 4;
  localparam logic [15:0] MODULUS   = 16'hFFF1;
  localparam int          c_mod_int = 65521;
  localparam int          c_n_rand  = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] value_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_accepts = 0;
  int n_results = 0;

  moduloaddsub_serial #(
    .MOD_LEN  (MOD_LEN),
    .MODULUS  (MODULUS),
    .LIMB_BITS(LIMB_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .value_out(value_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one operation for one edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a_in     = a;
    b_in     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_accepts++;
  endtask

  // lat counts clock edges from the accepting edge (inclusive) until
  // out_valid is first seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_results++;
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [15:0] exp);
    int lat;
    start_op(a, b, sub);
    wait_valid(lat);
    check(tag, 32'(value_out), 32'(exp));
    finish_op();
  endtask

  function automatic logic [15:0] ref_model(input int a, input int b, input logic sub);
    int r;
    if (sub) r = (a >= b) ? (a - b) : (a - b + c_mod_int);
    else     r = (a + b) % c_mod_int;
    return r[15:0];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          ra;
    int          rb;
    logic        rs;
    int          stall;
    logic [15:0] held;
    logic        leaked;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_value", 32'(value_out), 32'd0);

    // Add wrap to exactly zero, with latency measurement.
    start_op(16'd65520, 16'd1, 1'b0);
    wait_valid(lat);
    check("add_wrap_latency", 32'(lat), 32'd5);
    check("add_wrap_value", 32'(value_out), 32'd0);
    finish_op();

    do_op("add_reduce", 16'd40000, 16'd30000, 1'b0, 16'h117F);
    do_op("add_carry_chain", 16'h0FFF, 16'h0001, 1'b0, 16'h1000);
    do_op("add_mod_minus_one", 16'd65519, 16'd1, 1'b0, 16'd65520);
    do_op("sub_negative", 16'd5, 16'd7, 1'b1, 16'hFFEF);
    do_op("sub_positive", 16'd7, 16'd5, 1'b1, 16'd2);
    do_op("sub_equal", 16'd1234, 16'd1234, 1'b1, 16'd0);
    do_op("sub_to_mod_minus_one", 16'd0, 16'd1, 1'b1, 16'd65520);

    // Backpressure: result held for 6 cycles, input pulses ignored.
    start_op(16'd100, 16'd200, 1'b0);
    wait_valid(lat);
    held = value_out;
    check("bp_value", 32'(held), 32'd300);
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_value_stable", 32'(value_out), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      a_in     = 16'd11;
      b_in     = 16'd22;
      in_valid = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish_op();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_value_kept", 32'(value_out), 32'd300);
    do_op("bp_next_op", 16'd1000, 16'd999, 1'b1, 16'd1);

    // Reset while RUN is at limb index 2.
    do_op("pre_reset_op", 16'd7, 16'd5, 1'b1, 16'd2);
    start_op(16'd3, 16'd4, 1'b0);
    n_accepts--;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_value", 32'(value_out), 32'd0);
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) leaked = 1'b1;
      @(negedge clk);
    end
    check("abort_never_presented", 32'(leaked), 32'd0);
    do_op("post_abort_zero", 16'd0, 16'd0, 1'b0, 16'd0);

    // Randomised back-to-back operations with output stalls.
    for (int n = 0; n < c_n_rand; n++) begin
      ra    = int'($urandom_range(0, c_mod_int - 1));
      rb    = int'($urandom_range(0, c_mod_int - 1));
      rs    = $urandom_range(0, 1) == 1;
      stall = int'($urandom_range(0, 3));
      start_op(ra[15:0], rb[15:0], rs);
      wait_valid(lat);
      repeat (stall) @(negedge clk);
      check("rand_result", 32'(value_out), 32'(ref_model(ra, rb, rs)));
      finish_op();
    end
    check("accept_result_count", 32'(n_results), 32'(n_accepts));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
